// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives imem from the pc register, captures the
// returned word/fault into a 2-entry queue, and hands entries to decode.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val,
  output logic        faulted
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FAULT = 1'b1;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  logic [63:0] pc;
  logic [1:0]  count;
  logic [0:0]  state;
  entry_t      q [2];

  logic        pop;
  logic        fetch;
  logic        misaligned;
  logic        fault_now;
  entry_t      new_entry;

  always_comb begin
    pop        = (count != 2'd0) && out_ready;
    fetch      = (state == ST_RUN) && fetch_en && !redirect_en &&
                 (({30'd0, count} < DEPTH) || pop);
    misaligned = (pc[1:0] != 2'b00);
    fault_now  = misaligned || imem_exc_en;
  end

  // A misaligned pc never reaches memory semantics: imem inputs are ignored.
  always_comb begin
    new_entry    = '0;
    new_entry.pc = pc;
    if (misaligned) begin
      new_entry.instr    = NOP;
      new_entry.exc_en   = 1'b1;
      new_entry.exc_code = 4'd0;
      new_entry.exc_val  = pc;
    end else if (imem_exc_en) begin
      new_entry.instr    = NOP;
      new_entry.exc_en   = 1'b1;
      new_entry.exc_code = imem_exc_code;
      new_entry.exc_val  = imem_exc_val;
    end else begin
      new_entry.instr    = imem_instr;
      new_entry.exc_en   = 1'b0;
      new_entry.exc_code = imem_exc_code;
      new_entry.exc_val  = imem_exc_val;
    end
  end

  // pc holds on a fault so imem_addr keeps pointing at the faulting address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_en) begin
      pc    <= redirect_pc;
      state <= ST_RUN;
    end else if (fetch) begin
      if (fault_now) begin
        state <= ST_FAULT;
      end else begin
        pc <= pc + 64'd4;
      end
    end
  end

  // Shift-style queue: q[0] is always the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        q[i] <= '0;
      end
    end else if (redirect_en) begin
      count <= 2'd0;
    end else begin
      case ({fetch, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q[0] <= new_entry;
          end else begin
            q[1] <= new_entry;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q[0]  <= q[1];
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q[0] <= new_entry;
          end else begin
            q[0] <= q[1];
            q[1] <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = pc;
  assign out_valid    = (count != 2'd0);
  assign out_instr    = q[0].instr;
  assign out_pc       = q[0].pc;
  assign out_exc_en   = q[0].exc_en;
  assign out_exc_code = q[0].exc_code;
  assign out_exc_val  = q[0].exc_val;
  assign faulted      = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model driven by
// directed scenarios and a randomized phase.
module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;
  logic        faulted;

  int checks = 0;
  int errors = 0;

  logic        flt_on = 1'b0;
  logic [63:0] flt_addr = '0;
  logic [3:0]  flt_code = '0;

  fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code),
    .imem_exc_val(imem_exc_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_exc_en(out_exc_en), .out_exc_code(out_exc_code),
    .out_exc_val(out_exc_val), .faulted(faulted)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = addr>>2, optional fault at one address.
  always_comb begin
    imem_instr    = imem_addr[33:2];
    imem_exc_en   = flt_on && (imem_addr == flt_addr);
    imem_exc_code = imem_exc_en ? flt_code : 4'd0;
    imem_exc_val  = imem_exc_en ? imem_addr : 64'd0;
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  logic        m_fault;

  task automatic model_reset();
    mq.delete();
    m_pc    = RST_PC;
    m_fault = 1'b0;
  endtask

  task automatic model_tick();
    ent_t        e;
    logic [63:0] w;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (redirect_en) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_fault = 1'b0;
      return;
    end
    if (!m_fault && fetch_en && mq.size() < 2) begin
      e    = '0;
      e.pc = m_pc;
      if (m_pc % 4 != 0) begin
        e.instr = 32'h13; e.exc_en = 1'b1; e.code = 4'd0; e.val = m_pc;
        m_fault = 1'b1;
      end else if (flt_on && m_pc == flt_addr) begin
        e.instr = 32'h13; e.exc_en = 1'b1; e.code = flt_code; e.val = m_pc;
        m_fault = 1'b1;
      end else begin
        w = m_pc >> 2;
        e.instr = w[31:0];
        m_pc = m_pc + 64'd4;
      end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [230:0] obs();
    return {imem_addr, faulted, out_valid,
            out_valid ? {out_instr, out_pc, out_exc_en, out_exc_code, out_exc_val} : 165'd0};
  endfunction

  function automatic logic [230:0] expv();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {m_pc, m_fault, (mq.size() != 0), h};
  endfunction

  task automatic test_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_addr, faulted, out_valid, out_instr, out_pc, out_exc_en, out_exc_code, out_exc_val}
        !== {RST_PC, 1'b0, 1'b0, 165'd0}) begin
      errors++;
      $display("FAIL reset_state act addr=%h val=%b pc=%h instr=%h", imem_addr, out_valid, out_pc, out_instr);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_release cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_stream();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL stream cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    fetch_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      out_ready = (i >= 5);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL backpressure cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    fetch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_ready   = (i >= 3);
      redirect_en = (i == 3);
      redirect_pc = 64'h100;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL redirect_full cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    redirect_en = 1'b0;
  endtask

  task automatic test_fault();
    flt_on    = 1'b1;
    flt_addr  = 64'h2000;
    flt_code  = 4'd1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 26; i++) begin
      redirect_en = (i == 0) || (i == 20);
      redirect_pc = (i == 0) ? 64'h1FF0 : 64'h0;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL fault cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    redirect_en = 1'b0;
    flt_on      = 1'b0;
  endtask

  task automatic test_misaligned();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      redirect_en = (i == 0) || (i == 7);
      redirect_pc = (i == 0) ? 64'h102 : 64'h0;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL misaligned cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    redirect_en = 1'b0;
  endtask

  task automatic test_wrap();
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      redirect_en = (i == 0);
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL wrap cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    redirect_en = 1'b0;
  endtask

  task automatic test_random();
    flt_on   = 1'b1;
    flt_addr = 64'h40;
    flt_code = 4'd5;
    for (int i = 0; i < 400; i++) begin
      fetch_en    = ($urandom_range(0, 9) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect_en = ($urandom_range(0, 19) == 0);
      redirect_pc = 64'($urandom_range(0, 40)) * 64'd2;
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    redirect_en = 1'b0;
    flt_on      = 1'b0;
  endtask

  task automatic test_midreset();
    fetch_en    = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 64'h300;
    out_ready   = 1'b1;
    tick();
    redirect_en = 1'b0;
    out_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL midreset_fill cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, faulted, imem_addr} !== {1'b0, 1'b0, RST_PC}) begin
      errors++;
      $display("FAIL midreset_async act valid=%b faulted=%b addr=%h", out_valid, faulted, imem_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold act valid=%b exp 0", out_valid);
    end
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL midreset_restart cyc%0d act=%h exp=%h", i, obs(), expv());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_misaligned();
    test_wrap();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
